// File: rtl/alu_cluster.sv
// alu_cluster: N-lane integer execution cluster between the reservation
// stations and the CDB / branch-resolution logic.
//
// Ports (per-lane fields packed, lane i at [i*W +: W]):
//   clk, reset        clock; asynchronous active-high reset
//   flush             kills all in-flight work, blocks issue this cycle
//   issue_*           valid/ready issue port: op, operands, imm, pc,
//                     prediction, destination tag, ROB tag
//   cdb_*             held CDB result, drained by cdb_ready
//   br_*              one-cycle branch resolution pulse
//
// Optional feature macro: ALU_CLUSTER_MUL_EN adds a 2-cycle MUL (op 16).

module alu_cluster #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int PC_W  = 64,
    parameter int TAG_W = 8,
    parameter int ROB_W = 7,
    parameter int OP_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [LANES-1:0]       issue_valid,
    output logic [LANES-1:0]       issue_ready,
    input  logic [LANES*OP_W-1:0]  issue_op,
    input  logic [LANES*XLEN-1:0]  issue_rs1_val,
    input  logic [LANES*XLEN-1:0]  issue_rs2_val,
    input  logic [LANES*PC_W-1:0]  issue_imm,
    input  logic [LANES*PC_W-1:0]  issue_pc,
    input  logic [LANES-1:0]       issue_pred_taken,
    input  logic [LANES*TAG_W-1:0] issue_rd,
    input  logic [LANES*ROB_W-1:0] issue_rob_tag,
    output logic [LANES-1:0]       cdb_valid,
    input  logic [LANES-1:0]       cdb_ready,
    output logic [LANES*TAG_W-1:0] cdb_tag,
    output logic [LANES*XLEN-1:0]  cdb_data,
    output logic [LANES*ROB_W-1:0] cdb_rob_tag,
    output logic [LANES-1:0]       br_valid,
    output logic [LANES-1:0]       br_taken,
    output logic [LANES-1:0]       br_mispredict,
    output logic [LANES*PC_W-1:0]  br_target,
    output logic [LANES*ROB_W-1:0] br_rob_tag
);

    localparam int SH_W = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(6);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(15);
`ifdef ALU_CLUSTER_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(16);
`endif

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RES   = 2'd1
`ifdef ALU_CLUSTER_MUL_EN
        , S_MUL1 = 2'd2
`endif
    } state_t;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic [OP_W-1:0]  op;
            logic [XLEN-1:0]  a;
            logic [XLEN-1:0]  b;
            logic [PC_W-1:0]  pc;
            logic [PC_W-1:0]  imm;
            logic             slt;
            logic             ult;
            logic [XLEN-1:0]  res;
            logic             is_br;
            logic             taken;
            logic             rdy;
            logic             accept;
            state_t           state_q;
            state_t           state_d;
            logic [TAG_W-1:0] tag_q;
            logic [XLEN-1:0]  data_q;
            logic [ROB_W-1:0] rob_q;
            logic             brv_q;
            logic             brt_q;
            logic             brm_q;
            logic [PC_W-1:0]  brpc_q;
            logic [ROB_W-1:0] brrob_q;
`ifdef ALU_CLUSTER_MUL_EN
            logic             is_mul;
            logic [XLEN-1:0]  mul_a_q;
            logic [XLEN-1:0]  mul_b_q;
`endif

            assign op  = issue_op[i*OP_W +: OP_W];
            assign a   = issue_rs1_val[i*XLEN +: XLEN];
            assign b   = issue_rs2_val[i*XLEN +: XLEN];
            assign pc  = issue_pc[i*PC_W +: PC_W];
            assign imm = issue_imm[i*PC_W +: PC_W];
            assign slt = $signed(a) < $signed(b);
            assign ult = a < b;

            always_comb begin
                res   = '0;
                is_br = 1'b0;
                taken = 1'b0;
`ifdef ALU_CLUSTER_MUL_EN
                is_mul = 1'b0;
`endif
                case (op)
                    OP_ADD:  res = a + b;
                    OP_SUB:  res = a - b;
                    OP_SLL:  res = a << b[SH_W-1:0];
                    OP_SRL:  res = a >> b[SH_W-1:0];
                    OP_SRA:  res = $signed(a) >>> b[SH_W-1:0];
                    OP_SLT:  res = {{(XLEN-1){1'b0}}, slt};
                    OP_SLTU: res = {{(XLEN-1){1'b0}}, ult};
                    OP_AND:  res = a & b;
                    OP_OR:   res = a | b;
                    OP_XOR:  res = a ^ b;
                    OP_BEQ:  begin is_br = 1'b1; taken = (a == b); end
                    OP_BNE:  begin is_br = 1'b1; taken = (a != b); end
                    OP_BLT:  begin is_br = 1'b1; taken = slt;      end
                    OP_BGE:  begin is_br = 1'b1; taken = !slt;     end
                    OP_BLTU: begin is_br = 1'b1; taken = ult;      end
                    OP_BGEU: begin is_br = 1'b1; taken = !ult;     end
`ifdef ALU_CLUSTER_MUL_EN
                    OP_MUL:  is_mul = 1'b1;
`endif
                    default: res = '0;
                endcase
            end

            // A held result blocks issue unless the arbiter drains it now.
            assign rdy = !flush && (state_q == S_EMPTY ||
                         (state_q == S_RES && cdb_ready[i]));
            assign accept = issue_valid[i] && rdy;

            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = S_EMPTY;
                end else begin
                    case (state_q)
                        S_EMPTY, S_RES: begin
                            if (accept) begin
                                if (is_br) state_d = S_EMPTY;
`ifdef ALU_CLUSTER_MUL_EN
                                else if (is_mul) state_d = S_MUL1;
`endif
                                else state_d = S_RES;
                            end else if (state_q == S_RES && cdb_ready[i]) begin
                                state_d = S_EMPTY;
                            end
                        end
`ifdef ALU_CLUSTER_MUL_EN
                        S_MUL1: state_d = S_RES;
`endif
                        default: state_d = S_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= S_EMPTY;
                    tag_q   <= '0;
                    data_q  <= '0;
                    rob_q   <= '0;
                    brv_q   <= 1'b0;
                    brt_q   <= 1'b0;
                    brm_q   <= 1'b0;
                    brpc_q  <= '0;
                    brrob_q <= '0;
`ifdef ALU_CLUSTER_MUL_EN
                    mul_a_q <= '0;
                    mul_b_q <= '0;
`endif
                end else begin
                    state_q <= state_d;
                    brv_q   <= 1'b0;
                    if (accept) begin
                        if (is_br) begin
                            brv_q   <= 1'b1;
                            brt_q   <= taken;
                            brm_q   <= taken ^ issue_pred_taken[i];
                            brpc_q  <= taken ? pc + imm : pc + PC_W'(4);
                            brrob_q <= issue_rob_tag[i*ROB_W +: ROB_W];
                        end else begin
                            tag_q  <= issue_rd[i*TAG_W +: TAG_W];
                            rob_q  <= issue_rob_tag[i*ROB_W +: ROB_W];
                            data_q <= res;
`ifdef ALU_CLUSTER_MUL_EN
                            mul_a_q <= a;
                            mul_b_q <= b;
`endif
                        end
                    end
`ifdef ALU_CLUSTER_MUL_EN
                    // Product is formed in the second cycle from the
                    // operands captured at accept.
                    if (!flush && state_q == S_MUL1)
                        data_q <= mul_a_q * mul_b_q;
`endif
                end
            end

            assign issue_ready[i]                 = rdy;
            assign cdb_valid[i]                   = (state_q == S_RES);
            assign cdb_tag[i*TAG_W +: TAG_W]      = tag_q;
            assign cdb_data[i*XLEN +: XLEN]       = data_q;
            assign cdb_rob_tag[i*ROB_W +: ROB_W]  = rob_q;
            assign br_valid[i]                    = brv_q;
            assign br_taken[i]                    = brt_q;
            assign br_mispredict[i]               = brm_q;
            assign br_target[i*PC_W +: PC_W]      = brpc_q;
            assign br_rob_tag[i*ROB_W +: ROB_W]   = brrob_q;
        end
    endgenerate

endmodule

// File: tb/tb_alu_cluster.sv
// tb_alu_cluster: scoreboard bench for alu_cluster.
// Expected CDB/branch results are queued at issue and popped on output.

module tb_alu_cluster;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int PC_W  = 64;
    localparam int TAG_W = 8;
    localparam int ROB_W = 7;
    localparam int OP_W  = 5;
`ifdef ALU_CLUSTER_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [LANES-1:0]       issue_valid;
    logic [LANES-1:0]       issue_ready;
    logic [LANES*OP_W-1:0]  issue_op;
    logic [LANES*XLEN-1:0]  issue_rs1_val;
    logic [LANES*XLEN-1:0]  issue_rs2_val;
    logic [LANES*PC_W-1:0]  issue_imm;
    logic [LANES*PC_W-1:0]  issue_pc;
    logic [LANES-1:0]       issue_pred_taken;
    logic [LANES*TAG_W-1:0] issue_rd;
    logic [LANES*ROB_W-1:0] issue_rob_tag;
    logic [LANES-1:0]       cdb_valid;
    logic [LANES-1:0]       cdb_ready;
    logic [LANES*TAG_W-1:0] cdb_tag;
    logic [LANES*XLEN-1:0]  cdb_data;
    logic [LANES*ROB_W-1:0] cdb_rob_tag;
    logic [LANES-1:0]       br_valid;
    logic [LANES-1:0]       br_taken;
    logic [LANES-1:0]       br_mispredict;
    logic [LANES*PC_W-1:0]  br_target;
    logic [LANES*ROB_W-1:0] br_rob_tag;

    always #5 clk = ~clk;

    alu_cluster #(
        .LANES(LANES), .XLEN(XLEN), .PC_W(PC_W),
        .TAG_W(TAG_W), .ROB_W(ROB_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rs1_val(issue_rs1_val),
        .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .issue_rd(issue_rd), .issue_rob_tag(issue_rob_tag),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_rob_tag(cdb_rob_tag), .br_valid(br_valid),
        .br_taken(br_taken), .br_mispredict(br_mispredict),
        .br_target(br_target), .br_rob_tag(br_rob_tag)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [ROB_W-1:0] rob;
    } cdb_t;

    typedef struct packed {
        logic             taken;
        logic             mis;
        logic [PC_W-1:0]  target;
        logic [ROB_W-1:0] rob;
    } br_t;

    cdb_t cq [LANES][$];
    br_t  bq [LANES][$];
    logic m1 [LANES];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit is_branch(input logic [4:0] op);
        return op >= 5'd10 && op <= 5'd15;
    endfunction

    function automatic bit lt_s(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        return a < b;
    endfunction

    function automatic logic [31:0] model_res(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << sh;
            5'd3:  r = a >> sh;
            5'd4: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            5'd5:  r = {31'd0, lt_s(a, b)};
            5'd6:  r = {31'd0, a < b};
            5'd7:  r = a & b;
            5'd8:  r = a | b;
            5'd9:  r = a ^ b;
            5'd16: r = MUL_EN ? a * b : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic bit model_taken(input logic [4:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (op)
            5'd10: return a == b;
            5'd11: return a != b;
            5'd12: return lt_s(a, b);
            5'd13: return !lt_s(a, b);
            5'd14: return a < b;
            5'd15: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_lane(input int l, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] pc, input logic [63:0] imm,
                            input logic pred, input logic [7:0] rd,
                            input logic [6:0] rob);
        issue_valid[l]                  = 1'b1;
        issue_op[l*OP_W +: OP_W]        = op;
        issue_rs1_val[l*XLEN +: XLEN]   = a;
        issue_rs2_val[l*XLEN +: XLEN]   = b;
        issue_pc[l*PC_W +: PC_W]        = pc;
        issue_imm[l*PC_W +: PC_W]       = imm;
        issue_pred_taken[l]             = pred;
        issue_rd[l*TAG_W +: TAG_W]      = rd;
        issue_rob_tag[l*ROB_W +: ROB_W] = rob;
    endtask

    function automatic logic [31:0] data_of(input int l);
        return cdb_data[l*XLEN +: XLEN];
    endfunction

    function automatic logic [7:0] tag_of(input int l);
        return cdb_tag[l*TAG_W +: TAG_W];
    endfunction

    function automatic logic [6:0] rob_of(input int l);
        return cdb_rob_tag[l*ROB_W +: ROB_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane model: a queued CDB entry means RES, or MUL1 in the cycle
    // right after a MUL accept.
    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            logic in_m1;
            logic had;
            logic exp_rdy;
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] pc;
            logic [63:0] imm;
            logic        tk;
            cdb_t g;
            br_t  bg;
            cdb_t ce;
            br_t  be;

            in_m1 = m1[l];
            m1[l] = 1'b0;
            had = cq[l].size() != 0;

            check($sformatf("cdb_valid[%0d]", l), 128'(cdb_valid[l]),
                  128'(had && !in_m1));
            if (cdb_valid[l] && had) begin
                g = '{tag: tag_of(l), data: data_of(l), rob: rob_of(l)};
                check($sformatf("cdb_fields[%0d]", l), 128'(g),
                      128'(cq[l][0]));
                if (cdb_ready[l]) void'(cq[l].pop_front());
            end

            check($sformatf("br_valid[%0d]", l), 128'(br_valid[l]),
                  128'(bq[l].size() != 0));
            if (br_valid[l] && bq[l].size() != 0) begin
                bg = '{taken: br_taken[l], mis: br_mispredict[l],
                       target: br_target[l*PC_W +: PC_W],
                       rob: br_rob_tag[l*ROB_W +: ROB_W]};
                check($sformatf("br_fields[%0d]", l), 128'(bg),
                      128'(bq[l][0]));
                void'(bq[l].pop_front());
            end

            exp_rdy = !flush && (!had || (!in_m1 && cdb_ready[l]));
            check($sformatf("issue_ready[%0d]", l), 128'(issue_ready[l]),
                  128'(exp_rdy));

            if (flush) begin
                cq[l].delete();
                bq[l].delete();
            end else if (issue_valid[l] && issue_ready[l]) begin
                op  = issue_op[l*OP_W +: OP_W];
                a   = issue_rs1_val[l*XLEN +: XLEN];
                b   = issue_rs2_val[l*XLEN +: XLEN];
                pc  = issue_pc[l*PC_W +: PC_W];
                imm = issue_imm[l*PC_W +: PC_W];
                if (is_branch(op)) begin
                    tk = model_taken(op, a, b);
                    be.taken  = tk;
                    be.mis    = tk ^ issue_pred_taken[l];
                    be.target = tk ? pc + imm : pc + 64'd4;
                    be.rob    = issue_rob_tag[l*ROB_W +: ROB_W];
                    bq[l].push_back(be);
                end else begin
                    ce.tag  = issue_rd[l*TAG_W +: TAG_W];
                    ce.data = model_res(op, a, b);
                    ce.rob  = issue_rob_tag[l*ROB_W +: ROB_W];
                    cq[l].push_back(ce);
                    if (MUL_EN && op == 5'd16) m1[l] = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [11:0] roff;

        for (int l = 0; l < LANES; l++) m1[l] = 1'b0;
        reset            = 1'b1;
        flush            = 1'b0;
        issue_valid      = '0;
        issue_op         = '0;
        issue_rs1_val    = '0;
        issue_rs2_val    = '0;
        issue_imm        = '0;
        issue_pc         = '0;
        issue_pred_taken = '0;
        issue_rd         = '0;
        issue_rob_tag    = '0;
        cdb_ready        = '1;

        @(negedge clk);
        check("rst_cdb_valid", 128'(cdb_valid), 128'(0));
        check("rst_br_valid", 128'(br_valid), 128'(0));
        check("rst_br_flags", 128'({br_taken, br_mispredict}), 128'(0));
        check("rst_cdb_data", 128'(cdb_data), 128'(0));
        check("rst_cdb_tags", 128'({cdb_tag, cdb_rob_tag}), 128'(0));
        check("rst_br_target", 128'(br_target), 128'(0));
        check("rst_issue_ready", 128'(issue_ready), 128'(2'b11));
        step();
        reset = 1'b0;

        // ADD wrap, then back-to-back compares and SRA
        set_lane(0, 5'd0, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'd0, 1'b0, 8'd5, 7'd3);
        @(negedge clk);
        step();
        set_lane(0, 5'd5, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'd0, 1'b0, 8'd6, 7'd4);
        set_lane(1, 5'd6, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'd0, 1'b0, 8'd7, 7'd5);
        @(negedge clk);
        check("add_valid", 128'(cdb_valid[0]), 128'(1));
        check("add_data", 128'(data_of(0)), 128'(0));
        check("add_tag", 128'(tag_of(0)), 128'(5));
        check("add_rob", 128'(rob_of(0)), 128'(3));
        check("add_b2b_ready", 128'(issue_ready[0]), 128'(1));
        step();
        set_lane(0, 5'd4, 32'h8000_0000, 32'd4, 64'd0, 64'd0, 1'b0, 8'd8, 7'd6);
        issue_valid[1] = 1'b0;
        @(negedge clk);
        check("slt_data", 128'(data_of(0)), 128'(1));
        check("sltu_data", 128'(data_of(1)), 128'(0));
        step();
        issue_valid = '0;
        @(negedge clk);
        check("sra_data", 128'(data_of(0)), 128'(32'hF800_0000));

        // BEQ taken, predicted not taken
        step();
        set_lane(0, 5'd10, 32'h1234, 32'h1234, 64'h1000, 64'h40, 1'b0,
                 8'd0, 7'd9);
        @(negedge clk);
        step();
        issue_valid = '0;
        @(negedge clk);
        check("beq_br_valid", 128'(br_valid[0]), 128'(1));
        check("beq_taken", 128'(br_taken[0]), 128'(1));
        check("beq_target", 128'(br_target[63:0]), 128'(64'h1040));
        check("beq_mispredict", 128'(br_mispredict[0]), 128'(1));
        check("beq_no_cdb", 128'(cdb_valid[0]), 128'(0));
        step();
        @(negedge clk);
        check("beq_pulse_end", 128'(br_valid[0]), 128'(0));

        // CDB backpressure on lane 1
        step();
        cdb_ready[1] = 1'b0;
        set_lane(1, 5'd0, 32'd10, 32'd20, 64'd0, 64'd0, 1'b0, 8'd11, 7'd12);
        @(negedge clk);
        step();
        set_lane(1, 5'd9, 32'hFF, 32'h0F, 64'd0, 64'd0, 1'b0, 8'd13, 7'd14);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_valid", 128'(cdb_valid[1]), 128'(1));
            check("hold_data", 128'(data_of(1)), 128'(30));
            check("hold_tag", 128'(tag_of(1)), 128'(11));
            check("hold_ready", 128'(issue_ready[1]), 128'(0));
            step();
        end
        cdb_ready[1] = 1'b1;
        @(negedge clk);
        check("drain_ready", 128'(issue_ready[1]), 128'(1));
        step();
        issue_valid = '0;
        @(negedge clk);
        check("b2b_valid", 128'(cdb_valid[1]), 128'(1));
        check("b2b_data", 128'(data_of(1)), 128'(32'hF0));
        check("b2b_tag", 128'(tag_of(1)), 128'(13));

        // Flush with results pending on both lanes
        step();
        cdb_ready = 2'b00;
        set_lane(0, 5'd8, 32'd1, 32'd2, 64'd0, 64'd0, 1'b0, 8'd20, 7'd21);
        set_lane(1, 5'd1, 32'd5, 32'd7, 64'd0, 64'd0, 1'b0, 8'd22, 7'd23);
        @(negedge clk);
        step();
        flush = 1'b1;
        set_lane(0, 5'd0, 32'd100, 32'd1, 64'd0, 64'd0, 1'b0, 8'd30, 7'd31);
        set_lane(1, 5'd0, 32'd200, 32'd2, 64'd0, 64'd0, 1'b0, 8'd32, 7'd33);
        @(negedge clk);
        check("flush_ready", 128'(issue_ready), 128'(0));
        check("flush_pending", 128'(cdb_valid), 128'(2'b11));
        step();
        flush = 1'b0;
        issue_valid = '0;
        cdb_ready = 2'b11;
        @(negedge clk);
        check("post_flush_cdb", 128'(cdb_valid), 128'(0));
        check("post_flush_br", 128'(br_valid), 128'(0));
        repeat (3) step();

`ifdef ALU_CLUSTER_MUL_EN
        set_lane(0, 5'd16, 32'd7, 32'd6, 64'd0, 64'd0, 1'b0, 8'd40, 7'd41);
        @(negedge clk);
        step();
        issue_valid = '0;
        @(negedge clk);
        check("mul1_ready", 128'(issue_ready[0]), 128'(0));
        check("mul1_valid", 128'(cdb_valid[0]), 128'(0));
        step();
        @(negedge clk);
        check("mul_valid", 128'(cdb_valid[0]), 128'(1));
        check("mul_data", 128'(data_of(0)), 128'(42));
        step();
        set_lane(0, 5'd16, 32'd3, 32'd5, 64'd0, 64'd0, 1'b0, 8'd42, 7'd43);
        @(negedge clk);
        step();
        flush = 1'b1;
        issue_valid = '0;
        @(negedge clk);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("mul_flush_a", 128'(cdb_valid[0]), 128'(0));
        step();
        @(negedge clk);
        check("mul_flush_b", 128'(cdb_valid[0]), 128'(0));
        step();
`else
        set_lane(0, 5'd16, 32'd7, 32'd6, 64'd0, 64'd0, 1'b0, 8'd40, 7'd41);
        @(negedge clk);
        step();
        issue_valid = '0;
        @(negedge clk);
        check("op16_valid", 128'(cdb_valid[0]), 128'(1));
        check("op16_data", 128'(data_of(0)), 128'(0));
        check("op16_ready", 128'(issue_ready[0]), 128'(1));
        step();
`endif

        // Random traffic, checked by the scoreboard monitor
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 24) == 0);
            for (int l = 0; l < LANES; l++) begin
                cdb_ready[l] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    rop  = 5'($urandom_range(0, 17));
                    ra   = $urandom;
                    rb   = ($urandom_range(0, 2) == 0) ? ra : $urandom;
                    roff = 12'($urandom);
                    set_lane(l, rop, ra, rb, {$urandom, $urandom},
                             {{52{roff[11]}}, roff}, 1'($urandom),
                             8'($urandom), 7'($urandom));
                end else begin
                    issue_valid[l] = 1'b0;
                end
            end
            step();
        end

        flush = 1'b0;
        issue_valid = '0;
        cdb_ready = 2'b11;
        repeat (5) step();
        check("drain_empty", 128'(cq[0].size() + cq[1].size() +
              bq[0].size() + bq[1].size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
